// File: rtl/signed_digit_serializer_if.sv
// Handshake bundle for the signed-digit serializer: a parallel operand
// input stream and a digit-serial output stream.
interface signed_digit_serializer_if #(
  parameter int no_of_digits = 4,
  parameter int radix_bits   = 3
);
  logic [no_of_digits*radix_bits-1:0] D;
  logic                               d_valid;
  logic                               d_ready;
  logic signed [radix_bits-1:0]       q;
  logic                               q_valid;
  logic                               q_last;
  logic                               q_ready;

  // Serializer side: consumes operands, produces digits.
  modport slave (
    input  D, d_valid, q_ready,
    output d_ready, q, q_valid, q_last
  );

  // Environment side: supplies operands, consumes digits.
  modport master (
    output D, d_valid, q_ready,
    input  d_ready, q, q_valid, q_last
  );
endinterface

// File: rtl/signed_digit_serializer.sv
// Emits a packed signed-digit operand MSD first, one digit per transfer,
// optionally followed by a run of zero pad digits.
module signed_digit_serializer #(
  parameter int no_of_digits = 4,
  parameter int radix_bits   = 3,
  parameter int pad_digits   = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  signed_digit_serializer_if.slave     bus
);
  localparam int N    = no_of_digits;
  localparam int R    = radix_bits;
  localparam int P    = pad_digits;
  localparam int MAXC = (((N > P) ? N : P) > 2) ? ((N > P) ? N : P) : 2;
  localparam int CW   = $clog2(MAXC);

  localparam logic [CW-1:0] LAST_DIGIT = CW'(N - 1);
  localparam logic [CW-1:0] LAST_PAD   = CW'((P > 0) ? P - 1 : 0);

  typedef enum logic [1:0] {IDLE, SHIFT, PAD} state_t;

  state_t          state;
  logic [N*R-1:0]  sr;
  logic [CW-1:0]   cnt;
  logic            accept;
  logic            xfer;
  logic            last;

  // Outputs are decoded purely from state, cnt and sr.
  always_comb begin
    last = 1'b0;
    if (state == SHIFT && cnt == LAST_DIGIT && P == 0) last = 1'b1;
    if (state == PAD && cnt == LAST_PAD)               last = 1'b1;
    bus.q_last  = last;
    bus.q_valid = (state == SHIFT) || (state == PAD);
    bus.q       = (state == SHIFT) ? sr[N*R-1 -: R] : '0;
  end

  // Ready when empty, or when the final digit leaves this cycle so the
  // next operand follows with no bubble.
  always_comb begin
    bus.d_ready = ~reset & ((state == IDLE) | (last & bus.q_ready));
    accept      = bus.d_valid & bus.d_ready;
    xfer        = bus.q_valid & bus.q_ready;
  end

  // Operand load, digit shifting and pad counting.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sr    <= bus.D;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (xfer) begin
            if (cnt != LAST_DIGIT) begin
              sr  <= sr << R;
              cnt <= cnt + CW'(1);
            end else if (P > 0) begin
              state <= PAD;
              cnt   <= '0;
            end else if (accept) begin
              sr  <= bus.D;
              cnt <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        PAD: begin
          if (xfer) begin
            if (cnt != LAST_PAD) begin
              cnt <= cnt + CW'(1);
            end else if (accept) begin
              sr    <= bus.D;
              cnt   <= '0;
              state <= SHIFT;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_signed_digit_serializer.sv
// Bench for signed_digit_serializer: unpadded instance (a) with a digit
// scoreboard and word round-trip, plus a padded instance (b).
module tb_signed_digit_serializer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  signed_digit_serializer_if #(.no_of_digits(4), .radix_bits(3)) ifa ();
  signed_digit_serializer_if #(.no_of_digits(4), .radix_bits(3)) ifb ();

  signed_digit_serializer #(.no_of_digits(4), .radix_bits(3), .pad_digits(0)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa.slave));
  signed_digit_serializer #(.no_of_digits(4), .radix_bits(3), .pad_digits(2)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb.slave));

  localparam logic [11:0] OP1 = {3'b011, 3'b101, 3'b000, 3'b111};
  localparam logic [11:0] OP2 = 12'o1234;
  localparam logic [11:0] OP3 = 12'o7070;

  // Scoreboard for instance a: digits/last flags and whole words pushed on accept.
  logic [2:0]  sb_dig[$];
  logic        sb_last[$];
  logic [11:0] sb_word[$];
  logic [11:0] rebuilt = '0;
  logic [11:0] dtmp;
  logic [2:0]  exp_d;
  logic        exp_l;
  logic [11:0] exp_w;
  logic        hold_pend = 1'b0;
  logic [4:0]  hold_val;
  int          words_checked = 0;

  always begin
    @(negedge clk);
    #2;
    if (reset) begin
      sb_dig.delete(); sb_last.delete(); sb_word.delete();
      hold_pend = 1'b0;
    end else begin
      checks++;
      if (ifa.q_valid !== (sb_dig.size() != 0)) begin
        errors++;
        $display("FAIL sb_valid: q_valid=%b expected %b", ifa.q_valid, sb_dig.size() != 0);
      end
      if (hold_pend) begin
        checks++;
        if ({ifa.q_valid, ifa.q, ifa.q_last} !== hold_val) begin
          errors++;
          $display("FAIL sb_hold: {valid,q,last}=%b expected %b", {ifa.q_valid, ifa.q, ifa.q_last}, hold_val);
        end
      end
      hold_pend = (ifa.q_valid === 1'b1) && (ifa.q_ready === 1'b0);
      hold_val  = {ifa.q_valid, ifa.q, ifa.q_last};
      if (ifa.q_valid === 1'b1 && ifa.q_ready === 1'b1 && sb_dig.size() != 0) begin
        exp_d = sb_dig.pop_front();
        exp_l = sb_last.pop_front();
        checks++;
        if ({ifa.q, ifa.q_last} !== {exp_d, exp_l}) begin
          errors++;
          $display("FAIL sb_digit: q=%b last=%b expected q=%b last=%b", ifa.q, ifa.q_last, exp_d, exp_l);
        end
        rebuilt = {rebuilt[8:0], ifa.q};
        if (ifa.q_last === 1'b1 && sb_word.size() != 0) begin
          exp_w = sb_word.pop_front();
          words_checked++;
          checks++;
          if (rebuilt !== exp_w) begin
            errors++;
            $display("FAIL roundtrip: word=%o expected %o", rebuilt, exp_w);
          end
        end
      end
      if (ifa.d_valid === 1'b1 && ifa.d_ready === 1'b1) begin
        dtmp = ifa.D;
        for (int i = 3; i >= 0; i--) begin
          sb_dig.push_back(dtmp[3*i +: 3]);
          sb_last.push_back(i == 0);
        end
        sb_word.push_back(dtmp);
      end
    end
  end

  task automatic test_reset();
    ifa.d_valid = 1'b1; ifa.D = 12'o7777; ifa.q_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      checks++;
      if ({ifa.q_valid, ifa.q_last, ifa.q, ifa.d_ready} !== 6'b0) begin
        errors++;
        $display("FAIL reset_hold: {valid,last,q,d_ready}=%b expected 000000", {ifa.q_valid, ifa.q_last, ifa.q, ifa.d_ready});
      end
    end
    @(negedge clk);
    reset = 1'b0; ifa.d_valid = 1'b0;
    #1;
    checks++;
    if (ifa.d_ready !== 1'b1 || ifa.q_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: d_ready=%b q_valid=%b expected 1 0", ifa.d_ready, ifa.q_valid);
    end
    @(negedge clk); #1;
    checks++;
    if (ifa.q_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_noload: q_valid=%b expected 0", ifa.q_valid);
    end
  endtask

  task automatic test_single();
    logic [2:0] exp[4] = '{3'b011, 3'b101, 3'b000, 3'b111};
    @(negedge clk);
    ifa.D = OP1; ifa.d_valid = 1'b1; ifa.q_ready = 1'b1;
    #1;
    checks++;
    if (ifa.d_ready !== 1'b1) begin
      errors++; $display("FAIL single_ready: d_ready=%b expected 1", ifa.d_ready);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      ifa.d_valid = 1'b0; ifa.D = $urandom;
      #1;
      checks++;
      if ({ifa.q_valid, ifa.q, ifa.q_last} !== {1'b1, exp[k], k == 3}) begin
        errors++;
        $display("FAIL single_digit%0d: {valid,q,last}=%b expected %b", k, {ifa.q_valid, ifa.q, ifa.q_last}, {1'b1, exp[k], k == 3});
      end
    end
    @(negedge clk); #1;
    checks++;
    if (ifa.q_valid !== 1'b0) begin
      errors++; $display("FAIL single_end: q_valid=%b expected 0", ifa.q_valid);
    end
  endtask

  task automatic test_backpressure();
    logic       qr[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [2:0] exp[5] = '{3'b011, 3'b101, 3'b101, 3'b000, 3'b111};
    @(negedge clk);
    ifa.D = OP1; ifa.d_valid = 1'b1; ifa.q_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      ifa.d_valid = 1'b0; ifa.q_ready = qr[k];
      #1;
      checks++;
      if ({ifa.q_valid, ifa.q, ifa.q_last} !== {1'b1, exp[k], k == 4}) begin
        errors++;
        $display("FAIL bp_digit%0d: {valid,q,last}=%b expected %b", k, {ifa.q_valid, ifa.q, ifa.q_last}, {1'b1, exp[k], k == 4});
      end
    end
    ifa.q_ready = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (ifa.q_valid !== 1'b0) begin
      errors++; $display("FAIL bp_end: q_valid=%b expected 0", ifa.q_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp[8] = '{3'd3, 3'd5, 3'd0, 3'd7, 3'd1, 3'd2, 3'd3, 3'd4};
    @(negedge clk);
    ifa.D = OP1; ifa.d_valid = 1'b1; ifa.q_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      ifa.D = OP2; ifa.d_valid = (k <= 4);
      #1;
      checks++;
      if ({ifa.q_valid, ifa.q, ifa.q_last, ifa.d_ready} !== {1'b1, exp[k-1], k == 4 || k == 8, k == 4 || k == 8}) begin
        errors++;
        $display("FAIL b2b_cycle%0d: {valid,q,last,d_ready}=%b expected %b", k,
                 {ifa.q_valid, ifa.q, ifa.q_last, ifa.d_ready}, {1'b1, exp[k-1], k == 4 || k == 8, k == 4 || k == 8});
      end
    end
    @(negedge clk);
    ifa.d_valid = 1'b0;
    #1;
    checks++;
    if (ifa.q_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_end: q_valid=%b expected 0", ifa.q_valid);
    end
  endtask

  task automatic test_padding();
    logic [2:0] exp[6] = '{3'b011, 3'b101, 3'b000, 3'b111, 3'b000, 3'b000};
    @(negedge clk);
    ifb.D = OP1; ifb.d_valid = 1'b1; ifb.q_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      ifb.d_valid = 1'b0;
      #1;
      checks++;
      if ({ifb.q_valid, ifb.q, ifb.q_last} !== {1'b1, exp[k], k == 5}) begin
        errors++;
        $display("FAIL pad_digit%0d: {valid,q,last}=%b expected %b", k, {ifb.q_valid, ifb.q, ifb.q_last}, {1'b1, exp[k], k == 5});
      end
    end
    @(negedge clk); #1;
    checks++;
    if (ifb.q_valid !== 1'b0) begin
      errors++; $display("FAIL pad_end: q_valid=%b expected 0", ifb.q_valid);
    end
  endtask

  task automatic test_reset_midstream();
    logic [2:0] exp[4] = '{3'b111, 3'b000, 3'b111, 3'b000};
    @(negedge clk);
    ifa.D = OP1; ifa.d_valid = 1'b1; ifa.q_ready = 1'b1;
    @(negedge clk);
    ifa.d_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; ifa.D = OP3; ifa.d_valid = 1'b1;
    #1;
    checks++;
    if (ifa.q_valid !== 1'b0 || ifa.d_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset: q_valid=%b d_ready=%b expected 0 1", ifa.q_valid, ifa.d_ready);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      ifa.d_valid = 1'b0;
      #1;
      checks++;
      if ({ifa.q_valid, ifa.q, ifa.q_last} !== {1'b1, exp[k], k == 3}) begin
        errors++;
        $display("FAIL midreset_digit%0d: {valid,q,last}=%b expected %b", k, {ifa.q_valid, ifa.q, ifa.q_last}, {1'b1, exp[k], k == 3});
      end
    end
    @(negedge clk); #1;
  endtask

  task automatic test_round_trip();
    int accepted = 0;
    int cyc = 0;
    int base = words_checked;
    ifa.d_valid = 1'b1;
    while (accepted < 1000 && cyc < 30000) begin
      @(negedge clk);
      ifa.D = 12'($urandom);
      ifa.q_ready = 1'($urandom_range(0, 1));
      #1;
      if (ifa.d_valid === 1'b1 && ifa.d_ready === 1'b1) accepted++;
      cyc++;
    end
    ifa.d_valid = 1'b0; ifa.q_ready = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    checks++;
    if (accepted != 1000 || sb_word.size() != 0 || words_checked - base != 1000) begin
      errors++;
      $display("FAIL rt_drain: accepted=%0d pending=%0d words=%0d expected 1000 0 1000",
               accepted, sb_word.size(), words_checked - base);
    end
  endtask

  initial begin
    ifa.D = '0; ifa.d_valid = 1'b0; ifa.q_ready = 1'b1;
    ifb.D = '0; ifb.d_valid = 1'b0; ifb.q_ready = 1'b1;
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_padding();
    test_reset_midstream();
    test_round_trip();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
